// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, FSM states, default timeout.
package ysyx_23060201_lsu_pkg;

  // RV32I func3 width codes (loads use all five, stores use the first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Cycles allowed in WAIT before the access faults
  localparam int unsigned LSU_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational lane logic: byte mask, store-data replication, load extraction/extension, legality.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
(
  input  logic        wen,
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [15:0] sh;

  // Decode width code and lane offset into mask, data and fault flag
  always_comb begin
    sh        = 16'(rdata >> {off, 3'b000});
    mask      = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    illegal   = 1'b0;
    if (wen) begin
      case (func3)
        F3_B: begin
          mask      = 4'b0001 << off;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_H: begin
          mask      = 4'b0011 << off;
          wdata_rep = {2{wdata[15:0]}};
          illegal   = off[0];
        end
        F3_W: begin
          mask      = 4'b1111;
          wdata_rep = wdata;
          illegal   = |off;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (func3)
        F3_B: begin
          mask      = 4'b0001 << off;
          rdata_ext = {{24{sh[7]}}, sh[7:0]};
        end
        F3_BU: begin
          mask      = 4'b0001 << off;
          rdata_ext = {24'd0, sh[7:0]};
        end
        F3_H: begin
          mask      = 4'b0011 << off;
          rdata_ext = {{16{sh[15]}}, sh};
          illegal   = off[0];
        end
        F3_HU: begin
          mask      = 4'b0011 << off;
          rdata_ext = {16'd0, sh};
          illegal   = off[0];
        end
        F3_W: begin
          mask      = 4'b1111;
          rdata_ext = rdata;
          illegal   = |off;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one operation, runs a bounded bus transaction, returns a writeback pulse.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = LSU_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_func3,
  input  logic [4:0]            req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rsp_err,
  output logic                  wb_valid,
  output logic                  wb_wen,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  wb_fault
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e            state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [2:0]            func3_q;
  logic [4:0]            rd_q;
  logic                  fault_q;

  logic                  in_idle, in_req, in_resp, ld_ok, tmo_hit;
  logic                  al_wen;
  logic [2:0]            al_func3;
  logic [1:0]            al_off;
  logic [3:0]            al_mask;
  logic [31:0]           al_wdata_rep, al_rdata_ext;
  logic                  al_illegal;

  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign in_resp = (state_q == ST_RESP);
  assign tmo_hit = (cnt_q == TMO_LAST);
  assign ld_ok   = !wen_q && !fault_q;

  // One aligner serves both phases: in IDLE it checks the incoming request,
  // afterwards it decodes the captured copy for the bus and writeback.
  assign al_wen   = in_idle ? req_wen        : wen_q;
  assign al_func3 = in_idle ? req_func3      : func3_q;
  assign al_off   = in_idle ? req_addr[1:0]  : addr_q[1:0];

  ysyx_23060201_lsu_align u_align (
    .wen       (al_wen),
    .func3     (al_func3),
    .off       (al_off),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .mask      (al_mask),
    .wdata_rep (al_wdata_rep),
    .rdata_ext (al_rdata_ext),
    .illegal   (al_illegal)
  );

  // Next-state decode; a response in the final WAIT cycle beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = al_illegal ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid || tmo_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, timeout counter and captured operation/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      func3_q <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          func3_q <= req_func3;
          rd_q    <= req_rd;
          rdata_q <= '0;
          fault_q <= al_illegal;
        end
        ST_REQ: if (mem_req_ready) cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rsp_valid) begin
            rdata_q <= mem_rdata;
            fault_q <= mem_rsp_err;
          end else if (tmo_hit) begin
            fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready     = in_idle;
  assign mem_req_valid = in_req;
  assign mem_wen       = in_req & wen_q;
  assign mem_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata     = (in_req && wen_q) ? al_wdata_rep : '0;
  assign mem_wmask     = in_req ? al_mask : '0;
  assign wb_valid      = in_resp;
  assign wb_wen        = in_resp & ld_ok & (rd_q != 5'd0);
  assign wb_rd         = in_resp ? rd_q : '0;
  assign wb_data       = (in_resp && ld_ok) ? al_rdata_ext : '0;
  assign wb_fault      = in_resp & fault_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Self-checking bench for ysyx_23060201_lsu: directed plan cases plus randomized ops against a model.
module tb_ysyx_23060201_lsu;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_wen, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_func3(req_func3), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  typedef struct {
    bit          wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    bit          illegal;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] wb_data;
    bit          wb_wen;
    bit          fault;
    int          wb_cycle;
  } exp_t;

  typedef struct {
    bit          ready0, ready1, saw_mem, mem_unstable, m_wen;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    bit          wb_seen, wb_wen, wb_fault, wb_after, ready_after;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          wb_cycle;
  } obs_t;

  // Reference: access size from the width code, alignment by modulo, load value by shift and mask
  function automatic exp_t model(input op_t op, input logic [31:0] rdata, input bit err,
                                 input int rdy, input int rsp);
    exp_t e;
    int sz, off;
    bit tmo;
    logic [31:0] v;
    off = int'(op.addr % 4);
    sz = 0;
    if (op.wen) begin
      if (op.f3 == 3'd0) sz = 1; else if (op.f3 == 3'd1) sz = 2; else if (op.f3 == 3'd2) sz = 4;
    end else begin
      if (op.f3 == 3'd0 || op.f3 == 3'd4) sz = 1;
      else if (op.f3 == 3'd1 || op.f3 == 3'd5) sz = 2;
      else if (op.f3 == 3'd2) sz = 4;
    end
    e.illegal = 1'b1;
    if (sz != 0) e.illegal = (off % sz) != 0;
    e.addr  = op.addr - 32'(off);
    e.mask  = 4'(((1 << sz) - 1) << off);
    e.wdata = (sz == 1) ? (op.wdata % 256) * 32'h0101_0101 :
              (sz == 2) ? (op.wdata % 65536) * 32'h0001_0001 : op.wdata;
    v = rdata / (32'd1 << (8 * off));
    if (sz == 1) begin
      v = v % 256;
      if (op.f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (op.f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    tmo = !e.illegal && (rsp < 0 || rsp >= TMO);
    e.fault    = e.illegal || tmo || err;
    e.wb_data  = (op.wen || e.fault) ? 32'd0 : v;
    e.wb_wen   = !op.wen && !e.fault && op.rd != 5'd0;
    e.wb_cycle = e.illegal ? 1 : (tmo ? 2 + rdy + TMO : 3 + rdy + rsp);
    return e;
  endfunction

  // Drives one operation from an IDLE negedge; memory answers after rdy/rsp cycles (rsp<0: never)
  task automatic run_op(input op_t op, input logic [31:0] rdata, input bit err,
                        input int rdy, input int rsp, output obs_t ob);
    int cyc, rc, sc, phase;
    ob = '{default: 0};
    req_valid = 1'b1; req_wen = op.wen; req_func3 = op.f3;
    req_addr = op.addr; req_wdata = op.wdata; req_rd = op.rd;
    ob.ready0 = req_ready;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_func3 = 3'($urandom); req_rd = 5'($urandom); req_wen = 1'($urandom);
    ob.ready1 = req_ready;
    cyc = 1; rc = 0; sc = 0; phase = 0;
    while (cyc < 600 && !ob.wb_seen) begin
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b1; mem_rdata = $urandom;
      if (mem_req_valid) begin
        if (!ob.saw_mem) begin
          ob.saw_mem = 1'b1; ob.m_addr = mem_addr; ob.m_wdata = mem_wdata;
          ob.m_mask = mem_wmask; ob.m_wen = mem_wen;
        end else if (ob.m_addr !== mem_addr || ob.m_wdata !== mem_wdata ||
                     ob.m_mask !== mem_wmask || ob.m_wen !== mem_wen) begin
          ob.mem_unstable = 1'b1;
        end
      end
      if (wb_valid) begin
        ob.wb_seen = 1'b1; ob.wb_cycle = cyc; ob.wb_wen = wb_wen; ob.wb_rd = wb_rd;
        ob.wb_data = wb_data; ob.wb_fault = wb_fault;
      end else begin
        if (phase == 0 && mem_req_valid) begin
          if (rc == rdy) begin mem_req_ready = 1'b1; phase = 1; end else rc++;
        end else if (phase == 1) begin
          if (rsp >= 0 && sc == rsp) begin
            mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err; phase = 2;
          end else sc++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    @(negedge clk);
    ob.wb_after = wb_valid; ob.ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_func3 = 0; req_rd = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_rsp_err = 0;
    repeat (3) @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset.req_ready: got %b exp 1", req_ready); end
    tests_run++; if (mem_req_valid !== 1'b0 || mem_wen !== 1'b0) begin tests_failed++; $display("FAIL reset.mem_ctl: got %b%b exp 00", mem_req_valid, mem_wen); end
    tests_run++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wmask !== 4'd0) begin tests_failed++; $display("FAIL reset.mem_bus: got %h %h %h exp 0", mem_addr, mem_wdata, mem_wmask); end
    tests_run++; if (wb_valid !== 1'b0 || wb_wen !== 1'b0 || wb_fault !== 1'b0) begin tests_failed++; $display("FAIL reset.wb_ctl: got %b%b%b exp 000", wb_valid, wb_wen, wb_fault); end
    tests_run++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin tests_failed++; $display("FAIL reset.wb_bus: got %h %h exp 0", wb_rd, wb_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    op_t op; obs_t ob;
    op = '{wen: 0, f3: 3'b100, addr: 32'h8000_0003, wdata: 0, rd: 5'd7};
    run_op(op, 32'h80AB_CDEF, 0, 0, 0, ob);
    tests_run++; if (ob.m_addr !== 32'h8000_0000) begin tests_failed++; $display("FAIL lbu.mem_addr: got %h exp 80000000", ob.m_addr); end
    tests_run++; if (ob.wb_data !== 32'h0000_0080) begin tests_failed++; $display("FAIL lbu.wb_data: got %h exp 00000080", ob.wb_data); end
    tests_run++; if (ob.wb_wen !== 1'b1 || ob.wb_rd !== 5'd7) begin tests_failed++; $display("FAIL lbu.wb_wen_rd: got %b %0d exp 1 7", ob.wb_wen, ob.wb_rd); end
    tests_run++; if (ob.wb_cycle !== 3) begin tests_failed++; $display("FAIL lbu.latency: got %0d exp 3", ob.wb_cycle); end
    tests_run++; if (ob.ready1 !== 1'b0 || ob.wb_after !== 1'b0) begin tests_failed++; $display("FAIL lbu.pulses: ready1 %b wb_after %b exp 0 0", ob.ready1, ob.wb_after); end

    op = '{wen: 0, f3: 3'b001, addr: 32'h8000_0002, wdata: 0, rd: 5'd9};
    run_op(op, 32'h8001_1234, 0, 0, 0, ob);
    tests_run++; if (ob.wb_data !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL lh.wb_data: got %h exp ffff8001", ob.wb_data); end
    op.f3 = 3'b101;
    run_op(op, 32'h8001_1234, 0, 0, 0, ob);
    tests_run++; if (ob.wb_data !== 32'h0000_8001) begin tests_failed++; $display("FAIL lhu.wb_data: got %h exp 00008001", ob.wb_data); end

    op = '{wen: 1, f3: 3'b000, addr: 32'h8000_0001, wdata: 32'h0000_00A5, rd: 5'd3};
    run_op(op, 32'h0, 0, 0, 0, ob);
    tests_run++; if (ob.m_mask !== 4'b0010 || ob.m_wdata !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL sb.bus: got %b %h exp 0010 a5a5a5a5", ob.m_mask, ob.m_wdata); end
    tests_run++; if (ob.m_wen !== 1'b1 || ob.wb_wen !== 1'b0 || ob.wb_fault !== 1'b0 || !ob.wb_seen) begin tests_failed++; $display("FAIL sb.wb: got mwen %b wen %b fault %b seen %b exp 1 0 0 1", ob.m_wen, ob.wb_wen, ob.wb_fault, ob.wb_seen); end

    op = '{wen: 0, f3: 3'b010, addr: 32'h8000_0002, wdata: 0, rd: 5'd4};
    run_op(op, 32'h1234_5678, 0, 0, 0, ob);
    tests_run++; if (ob.saw_mem !== 1'b0) begin tests_failed++; $display("FAIL lw_mis.no_bus: got %b exp 0", ob.saw_mem); end
    tests_run++; if (ob.wb_cycle !== 1 || ob.wb_fault !== 1'b1 || ob.wb_data !== 32'd0 || ob.wb_wen !== 1'b0) begin tests_failed++; $display("FAIL lw_mis.wb: got cyc %0d fault %b data %h wen %b exp 1 1 0 0", ob.wb_cycle, ob.wb_fault, ob.wb_data, ob.wb_wen); end

    op = '{wen: 0, f3: 3'b010, addr: 32'h8000_0010, wdata: 0, rd: 5'd4};
    run_op(op, 32'h1234_5678, 1, 1, 2, ob);
    tests_run++; if (ob.wb_fault !== 1'b1 || ob.wb_data !== 32'd0 || ob.wb_cycle !== 6) begin tests_failed++; $display("FAIL bus_err.wb: got fault %b data %h cyc %0d exp 1 0 6", ob.wb_fault, ob.wb_data, ob.wb_cycle); end
  endtask

  task automatic test_timeout();
    op_t op; obs_t ob;
    op = '{wen: 0, f3: 3'b010, addr: 32'h8000_0100, wdata: 0, rd: 5'd3};
    run_op(op, 32'hDEAD_BEEF, 0, 5, -1, ob);
    tests_run++; if (ob.wb_cycle !== 2 + 5 + TMO || ob.wb_fault !== 1'b1) begin tests_failed++; $display("FAIL timeout.wb: got cyc %0d fault %b exp %0d 1", ob.wb_cycle, ob.wb_fault, 2 + 5 + TMO); end
    tests_run++; if (ob.wb_data !== 32'd0 || ob.wb_wen !== 1'b0) begin tests_failed++; $display("FAIL timeout.data: got %h %b exp 0 0", ob.wb_data, ob.wb_wen); end
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      tests_run++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL late_rsp.%0d: got wb %b ready %b exp 0 1", i, wb_valid, req_ready); end
    end
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    run_op(op, 32'h0BAD_F00D, 0, 0, TMO - 1, ob);
    tests_run++; if (ob.wb_cycle !== 3 + TMO - 1 || ob.wb_fault !== 1'b0 || ob.wb_data !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL rsp_edge.wb: got cyc %0d fault %b data %h exp %0d 0 0badf00d", ob.wb_cycle, ob.wb_fault, ob.wb_data, 3 + TMO - 1); end
    run_op(op, 32'h0BAD_F00D, 0, 0, TMO, ob);
    tests_run++; if (ob.wb_cycle !== 2 + TMO || ob.wb_fault !== 1'b1) begin tests_failed++; $display("FAIL rsp_late.wb: got cyc %0d fault %b exp %0d 1", ob.wb_cycle, ob.wb_fault, 2 + TMO); end
  endtask

  task automatic test_back_to_back();
    op_t a, b; obs_t oa, ob;
    a = '{wen: 1, f3: 3'b001, addr: 32'h1000_0002, wdata: 32'h1234_BEEF, rd: 5'd1};
    b = '{wen: 0, f3: 3'b000, addr: 32'h1000_0001, wdata: 0, rd: 5'd31};
    run_op(a, 32'h0, 0, 0, 0, oa);
    run_op(b, 32'h0000_F100, 0, 0, 0, ob);
    tests_run++; if (oa.m_mask !== 4'b1100 || oa.m_wdata !== 32'hBEEF_BEEF) begin tests_failed++; $display("FAIL b2b.sh: got %b %h exp 1100 beefbeef", oa.m_mask, oa.m_wdata); end
    tests_run++; if (oa.ready_after !== 1'b1 || ob.ready0 !== 1'b1 || ob.wb_cycle !== 3) begin tests_failed++; $display("FAIL b2b.accept: got %b %b cyc %0d exp 1 1 3", oa.ready_after, ob.ready0, ob.wb_cycle); end
    tests_run++; if (ob.wb_data !== 32'hFFFF_FFF1 || ob.wb_rd !== 5'd31) begin tests_failed++; $display("FAIL b2b.lb: got %h %0d exp fffffff1 31", ob.wb_data, ob.wb_rd); end
  endtask

  task automatic test_random();
    op_t op; obs_t ob; exp_t e;
    logic [31:0] rdata; bit err; int rdy, rsp;
    for (int n = 0; n < 60; n++) begin
      op.wen = 1'($urandom); op.f3 = 3'($urandom); op.addr = $urandom;
      op.wdata = $urandom; op.rd = 5'($urandom);
      if ($urandom_range(3) != 0) op.f3 = (op.wen) ? 3'($urandom_range(2)) : 3'($urandom_range(5));
      if ($urandom_range(1) == 0) op.addr[1:0] = 2'b00;
      rdata = $urandom; err = ($urandom_range(7) == 0);
      rdy = $urandom_range(3); rsp = $urandom_range(3);
      e = model(op, rdata, err, rdy, rsp);
      run_op(op, rdata, err, rdy, rsp, ob);
      tests_run++; if (ob.ready0 !== 1'b1 || ob.ready1 !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d.ready: got %b%b exp 10", n, ob.ready0, ob.ready1); end
      tests_run++; if (ob.saw_mem !== !e.illegal) begin tests_failed++; $display("FAIL rnd%0d.bus_used: got %b exp %b", n, ob.saw_mem, !e.illegal); end
      if (!e.illegal) begin
        tests_run++; if (ob.m_addr !== e.addr || ob.m_wen !== op.wen || ob.mem_unstable) begin tests_failed++; $display("FAIL rnd%0d.mem_req: got %h %b unst %b exp %h %b 0", n, ob.m_addr, ob.m_wen, ob.mem_unstable, e.addr, op.wen); end
        if (op.wen) begin
          tests_run++; if (ob.m_mask !== e.mask || ob.m_wdata !== e.wdata) begin tests_failed++; $display("FAIL rnd%0d.store: got %b %h exp %b %h", n, ob.m_mask, ob.m_wdata, e.mask, e.wdata); end
        end
      end
      tests_run++; if (!ob.wb_seen || ob.wb_cycle !== e.wb_cycle) begin tests_failed++; $display("FAIL rnd%0d.latency: got %0d (seen %b) exp %0d", n, ob.wb_cycle, ob.wb_seen, e.wb_cycle); end
      tests_run++; if (ob.wb_data !== e.wb_data || ob.wb_fault !== e.fault) begin tests_failed++; $display("FAIL rnd%0d.wb: got %h f%b exp %h f%b", n, ob.wb_data, ob.wb_fault, e.wb_data, e.fault); end
      tests_run++; if (ob.wb_wen !== e.wb_wen || ob.wb_rd !== op.rd) begin tests_failed++; $display("FAIL rnd%0d.wb_dst: got %b %0d exp %b %0d", n, ob.wb_wen, ob.wb_rd, e.wb_wen, op.rd); end
      tests_run++; if (ob.wb_after !== 1'b0 || ob.ready_after !== 1'b1) begin tests_failed++; $display("FAIL rnd%0d.after: got %b %b exp 0 1", n, ob.wb_after, ob.ready_after); end
    end
  endtask

  task automatic test_reset_in_wait();
    op_t op; obs_t ob;
    req_valid = 1'b1; req_wen = 1'b0; req_func3 = 3'b010; req_addr = 32'h8000_0040; req_rd = 5'd6;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wait.busy: got ready %b mreq %b exp 0 0", req_ready, mem_req_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0 || wb_fault !== 1'b0 || wb_data !== 32'd0) begin tests_failed++; $display("FAIL rst_wait.clear: got %b %b %b %b %h exp 1 0 0 0 0", req_ready, mem_req_valid, wb_valid, wb_fault, wb_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1; mem_rdata = $urandom; mem_rsp_err = 1'b0;
      @(negedge clk);
      tests_run++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_wait.ignore%0d: got wb %b ready %b exp 0 1", i, wb_valid, req_ready); end
    end
    mem_rsp_valid = 1'b0;
    op = '{wen: 0, f3: 3'b010, addr: 32'h8000_0080, wdata: 0, rd: 5'd0};
    run_op(op, 32'hCAFE_0001, 0, 0, 0, ob);
    tests_run++; if (!ob.wb_seen || ob.wb_wen !== 1'b0 || ob.wb_fault !== 1'b0 || ob.wb_data !== 32'hCAFE_0001 || ob.wb_cycle !== 3) begin tests_failed++; $display("FAIL rst_wait.lw_x0: got seen %b wen %b f %b %h cyc %0d exp 1 0 0 cafe0001 3", ob.wb_seen, ob.wb_wen, ob.wb_fault, ob.wb_data, ob.wb_cycle); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
